mod_shiftrows_pipe: RTL

MOD_SHIFTROWS_PIPE -- requirements
Module: mod_shiftrows_pipe

---
 rtl/mod_aes_pkg.sv | 25 ++
 rtl/mod_pipe_stage.sv | 31 +++
 rtl/mod_shiftrows_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/mod_aes_pkg.sv
// Shared AES byte-state helpers: byte type, ShiftRows row offsets and the
// column-count legality check used at elaboration.
package mod_aes_pkg;

   typedef logic [7:0] byte_t;

   // Row 0 never moves; the 256-bit state (NB=8) widens the offsets of rows 2 and 3 by one.
   function automatic int row_offset(input int r, input int nb);
      if (r == 0) return 0;
      if (nb == 8 && r >= 2) return r + 1;
      return r;
   endfunction

   function automatic bit nb_legal(input int nb);
      return (nb == 4) || (nb == 6) || (nb == 8);
   endfunction

   function automatic int src_col(input int c, input int r, input int nb, input bit inv);
      int off;
      off = row_offset(r, nb);
      if (inv) return (c - off + nb) % nb;
      return (c + off) % nb;
   endfunction

endpackage

// File: rtl/mod_pipe_stage.sv
// One register slice of the valid/ready pipe; the parent decides when it may
// load (empty, or its successor is loading this cycle).
module mod_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         load,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   // Payload only changes when a real word arrives, so idle outputs stay quiet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/mod_shiftrows_pipe.sv
// AES ShiftRows / InvShiftRows applied combinationally at the input, followed
// by STAGES elastic register slices carrying {valid, inv, data}.
module mod_shiftrows_pipe
   import mod_aes_pkg::*;
#(
   parameter int  NB     = 4,
   parameter int  STAGES = 2,
   localparam int BYTES  = 4 * NB,
   localparam int LW     = $clog2(STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_inv,
   input  logic [BYTES-1:0][7:0] in_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_inv,
   output logic [BYTES-1:0][7:0] out_data,
   output logic [LW-1:0]         level
);

   localparam int PW = 1 + 8 * BYTES;
   localparam int IW = $clog2(BYTES);

   if (!nb_legal(NB)) begin : g_bad_nb
      $error("mod_shiftrows_pipe: NB must be 4, 6 or 8");
   end
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("mod_shiftrows_pipe: STAGES must be in 1..4");
   end

   byte_t [BYTES-1:0] shifted;
   logic [PW-1:0]     head;
   logic [STAGES-1:0] sv;
   logic [STAGES-1:0] load;
   logic [PW-1:0]     sd [STAGES];
   logic              accept_in;
   logic              accept_out;

   // Both rotations are static wiring; the mode bit just picks between them per byte.
   always_comb begin
      shifted = '0;
      for (int c = 0; c < NB; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[IW'(4 * c + r)] = in_inv ? in_data[IW'(4 * src_col(c, r, NB, 1'b1) + r)]
                                             : in_data[IW'(4 * src_col(c, r, NB, 1'b0) + r)];
         end
      end
   end

   assign head = {in_inv, shifted};

   // Ready ripples back from the output: a slice may take a word if it is empty or draining.
   always_comb begin
      load = '0;
      load[STAGES-1] = !sv[STAGES-1] || out_ready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         load[k] = !sv[k] || load[k+1];
      end
   end

   assign in_ready   = load[0] && !flush && !rst;
   assign accept_in  = in_valid && in_ready;
   assign out_valid  = sv[STAGES-1];
   assign accept_out = out_valid && out_ready;
   assign {out_inv, out_data} = sd[STAGES-1];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic          stg_in_valid;
      logic [PW-1:0] stg_in_data;

      if (k == 0) begin : g_head
         assign stg_in_valid = accept_in;
         assign stg_in_data  = head;
      end else begin : g_body
         assign stg_in_valid = sv[k-1];
         assign stg_in_data  = sd[k-1];
      end

      mod_pipe_stage #(.W(PW)) u_stage (
         .clk      (clk),
         .rst      (rst),
         .flush    (flush),
         .load     (load[k]),
         .in_valid (stg_in_valid),
         .in_data  (stg_in_data),
         .out_valid(sv[k]),
         .out_data (sd[k])
      );
   end

   // Occupancy tracks handshakes so a simultaneous enter/leave nets to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= '0;
      end else if (flush) begin
         level <= '0;
      end else if (accept_in && !accept_out) begin
         level <= level + LW'(1);
      end else if (!accept_in && accept_out) begin
         level <= level - LW'(1);
      end
   end

endmodule
